// File: rtl/ni_flit_tx.sv
// rtl/ni_flit_tx.sv - NoC flit transmitter: packet FIFO feeding a head/body/tail serializer
package ni_pkg;
  localparam int TOTAL_FLITS = 4;
endpackage

module ni_flit_tx #(
  parameter int FLIT_W      = 16,
  parameter int TOTAL_FLITS = ni_pkg::TOTAL_FLITS,
  parameter int DEPTH       = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                pkt_valid,
  input  logic [FLIT_W-1:0]   pkt_head,
  input  logic [((TOTAL_FLITS > 2) ? (TOTAL_FLITS-2)*FLIT_W : 1)-1:0] pkt_body,
  input  logic [FLIT_W-1:0]   pkt_tail,
  output logic                pkt_ready,
  output logic [FLIT_W-1:0]   o_flit,
  output logic                o_enable,
  input  logic                i_ready,
  output logic                tx_done,
  output logic [15:0]         pkt_count
);

  localparam int N_BODY = TOTAL_FLITS - 2;
  localparam int PKT_W  = TOTAL_FLITS * FLIT_W;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int IW     = (N_BODY > 1) ? $clog2(N_BODY) : 1;

  // Packet word layout: head in the low flit, then body[0..], tail in the top flit.
  logic [PKT_W-1:0] pkt_word;
  if (N_BODY > 0) begin : g_body
    assign pkt_word = {pkt_tail, pkt_body, pkt_head};
  end else begin : g_no_body
    assign pkt_word = {pkt_tail, pkt_head};
  end

  logic [PKT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic [PKT_W-1:0] rd_word;

  assign fifo_full  = (count == CW'(DEPTH));
  assign fifo_empty = (count == '0);
  assign pkt_ready  = !fifo_full && !reset;
  assign push       = pkt_valid && pkt_ready;
  assign rd_word    = mem[rd_ptr];

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [FLIT_W-1:0] flit_at(input logic [PKT_W-1:0] w, input int k);
    return w[k*FLIT_W +: FLIT_W];
  endfunction

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pkt_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  typedef enum logic [1:0] {S_IDLE, S_HEAD, S_BODY, S_TAIL} state_t;

  state_t           state_q, state_d;
  logic [PKT_W-1:0] shadow_q, shadow_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [15:0]      pkt_count_q, pkt_count_d;
  logic             xfer;

  assign xfer = en_q && i_ready;

  // The popped packet lives in the shadow register so the FIFO slot frees at head time.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    flit_d      = flit_q;
    en_d        = en_q;
    idx_d       = idx_q;
    done_d      = 1'b0;
    pop         = 1'b0;
    pkt_count_d = pkt_count_q;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          shadow_d = rd_word;
          flit_d   = flit_at(rd_word, 0);
          en_d     = 1'b1;
          state_d  = S_HEAD;
        end
      end
      S_HEAD: begin
        if (xfer) begin
          idx_d = '0;
          if (N_BODY > 0) begin
            flit_d  = flit_at(shadow_q, 1);
            state_d = S_BODY;
          end else begin
            flit_d  = flit_at(shadow_q, TOTAL_FLITS - 1);
            state_d = S_TAIL;
          end
        end
      end
      S_BODY: begin
        if (xfer) begin
          if (idx_q == IW'(N_BODY - 1)) begin
            flit_d  = flit_at(shadow_q, TOTAL_FLITS - 1);
            state_d = S_TAIL;
          end else begin
            idx_d  = idx_q + IW'(1);
            flit_d = flit_at(shadow_q, int'(idx_q) + 2);
          end
        end
      end
      S_TAIL: begin
        if (xfer) begin
          done_d = 1'b1;
          if (!fifo_empty) begin
            pop      = 1'b1;
            shadow_d = rd_word;
            flit_d   = flit_at(rd_word, 0);
            state_d  = S_HEAD;
          end else begin
            en_d    = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (done_d) pkt_count_d = pkt_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      flit_q      <= '0;
      en_q        <= 1'b0;
      done_q      <= 1'b0;
      idx_q       <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      flit_q      <= flit_d;
      en_q        <= en_d;
      done_q      <= done_d;
      idx_q       <= idx_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign o_flit    = flit_q;
  assign o_enable  = en_q;
  assign tx_done   = done_q;
  assign pkt_count = pkt_count_q;

endmodule

// File: tb/tb_ni_flit_tx.sv
// tb/tb_ni_flit_tx.sv - scoreboard bench for ni_flit_tx with directed packets
module tb_ni_flit_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pkt_valid = 1'b0;
  logic [15:0] pkt_head = '0;
  logic [31:0] pkt_body = '0;
  logic [15:0] pkt_tail = '0;
  logic        pkt_ready;
  logic [15:0] o_flit;
  logic        o_enable;
  logic        i_ready = 1'b1;
  logic        tx_done;
  logic [15:0] pkt_count;

  ni_flit_tx #(.FLIT_W(16), .TOTAL_FLITS(4), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .pkt_head(pkt_head),
    .pkt_body(pkt_body), .pkt_tail(pkt_tail), .pkt_ready(pkt_ready),
    .o_flit(o_flit), .o_enable(o_enable), .i_ready(i_ready),
    .tx_done(tx_done), .pkt_count(pkt_count)
  );

  typedef struct { logic [15:0] flit; bit tail; } exp_t;

  exp_t        sb[$];
  int          xfer_cyc[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_tail_cyc = -10;
  bit          prev_stall = 1'b0;
  logic [15:0] prev_flit = '0;
  exp_t        mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every flit transfer is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_enable", o_enable, 1);
        check("stall_hold_flit", o_flit, prev_flit);
      end
      if (tx_done) begin
        done_cnt++;
        check("tx_done_cycle", cyc, last_tail_cyc + 1);
      end
      if (o_enable && i_ready) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_flit: got 0x%0h with empty scoreboard (cycle %0d)", o_flit, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("flit_value", o_flit, mon_e.flit);
          xfer_cyc.push_back(cyc);
          if (mon_e.tail) last_tail_cyc = cyc;
        end
      end
      prev_stall = o_enable && !i_ready;
      prev_flit  = o_flit;
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send_pkt(input logic [15:0] h, input logic [15:0] b0, input logic [15:0] b1,
                          input logic [15:0] t, output int acc);
    int n = 0;
    pkt_valid = 1'b1;
    pkt_head  = h;
    pkt_body  = {b1, b0};
    pkt_tail  = t;
    forever begin
      @(negedge clk);
      if (pkt_ready) break;
      n++;
      if (n > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    sb.push_back('{h, 1'b0});
    sb.push_back('{b0, 1'b0});
    sb.push_back('{b1, 1'b0});
    sb.push_back('{t, 1'b1});
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sb.size() == 0 && !o_enable && !tx_done) && n < 300);
    check({name, "_drained"}, (sb.size() == 0 && !o_enable), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    pkt_valid = 1'b0;
    i_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    xfer_cyc.delete();
    done_cnt = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int e;
    int n2;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_o_enable", o_enable, 0);
    check("rst_o_flit", o_flit, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_pkt_ready", pkt_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_release_ready", pkt_ready, 1);
    @(posedge clk); #1;

    // Reset during an active packet
    send_pkt(16'hA001, 16'h1111, 16'h2222, 16'hB00F, n);
    pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", pkt_ready, 0);
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk);
    check("midrst_enable", o_enable, 0);
    check("midrst_tx_done", tx_done, 0);
    check("midrst_count", pkt_count, 0);
    check("midrst_ready_low2", pkt_ready, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_release_ready", pkt_ready, 1);
    repeat (8) @(negedge clk);
    check("midrst_no_done", done_cnt, 0);
    check("midrst_enable_after", o_enable, 0);
    @(posedge clk); #1;

    // Single packet, exact latency
    do_reset();
    send_pkt(16'hA001, 16'h1111, 16'h2222, 16'hB00F, n);
    pkt_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("single_enable_low", o_enable, 0);
    check("single_tx_done", tx_done, 1);
    @(posedge clk); #1;
    wait_idle("single");
    for (int i = 0; i < 4; i++)
      check("single_flit_cycle", (xfer_cyc.size() > i) ? xfer_cyc[i] : -1, n + 1 + i);
    check("single_done_cnt", done_cnt, 1);
    check("single_pkt_count", pkt_count, 1);

    // Back-pressure on the first body flit
    do_reset();
    send_pkt(16'hA001, 16'h1111, 16'h2222, 16'hB00F, n);
    pkt_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_flit", o_flit, 16'h1111);
      check("bp_hold_enable", o_enable, 1);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    wait_idle("bp");
    check("bp_flit_count", xfer_cyc.size(), 4);
    check("bp_body0_cycle", (xfer_cyc.size() > 1) ? xfer_cyc[1] : -1, n + 5);
    check("bp_done_cnt", done_cnt, 1);
    check("bp_pkt_count", pkt_count, 1);

    // Back-to-back packets
    do_reset();
    send_pkt(16'hA001, 16'h1111, 16'h2222, 16'hB00F, n);
    send_pkt(16'hA002, 16'h3333, 16'h4444, 16'hB010, e);
    pkt_valid = 1'b0;
    check("b2b_accept_edge", e, n + 1);
    wait_idle("b2b");
    check("b2b_flit_count", xfer_cyc.size(), 8);
    for (int i = 0; i < 8; i++)
      check("b2b_flit_cycle", (xfer_cyc.size() > i) ? xfer_cyc[i] : -1, n + 1 + i);
    check("b2b_done_cnt", done_cnt, 2);
    check("b2b_pkt_count", pkt_count, 2);

    // Full FIFO plus shadow, then drain
    do_reset();
    i_ready = 1'b0;
    send_pkt(16'hA001, 16'h1111, 16'h2222, 16'hB00F, n);
    send_pkt(16'hA002, 16'h3333, 16'h4444, 16'hB010, e);
    send_pkt(16'hA003, 16'h5555, 16'h6666, 16'hB011, n2);
    check("full_third_accept", n2, n + 2);
    pkt_head = 16'hA004;
    pkt_body = {16'h8888, 16'h7777};
    pkt_tail = 16'hB012;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_ready_low", pkt_ready, 0);
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    e = cyc;
    send_pkt(16'hA004, 16'h7777, 16'h8888, 16'hB012, n);
    pkt_valid = 1'b0;
    check("full_reaccept_edge", n, e + 5);
    wait_idle("full");
    check("full_flit_count", xfer_cyc.size(), 16);
    check("full_done_cnt", done_cnt, 4);
    check("full_pkt_count", pkt_count, 4);

    // pkt_count wrap
    do_reset();
    @(negedge clk);
    force dut.pkt_count_q = 16'hFFFF;
    @(posedge clk); #1;
    @(negedge clk);
    release dut.pkt_count_q;
    check("wrap_preload", pkt_count, 16'hFFFF);
    @(posedge clk); #1;
    send_pkt(16'hA002, 16'h3333, 16'h4444, 16'hB010, n);
    pkt_valid = 1'b0;
    wait_idle("wrap");
    check("wrap_pkt_count", pkt_count, 16'h0000);
    check("wrap_done_cnt", done_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ni_flit_tx.md
# ni_flit_tx

Flit transmitter for the NoC side of the network interface. It accepts whole request packets (one head flit, TOTAL_FLITS-2 body flits and one tail flit) on a valid/ready port and buffers them in a small packet FIFO. It serializes each packet onto the 16-bit flit link (`o_flit`/`o_enable`) and honours the NI's `ready` back-pressure. It is the synthesizable transmitter counterpart of the NI flit receiver, and it replaces ad-hoc bench drivers in system-level simulations.

## Interface
- `FLIT_W`, default 16: flit width in bits.
- `TOTAL_FLITS`, default `ni_pkg::TOTAL_FLITS` (4 in all tests): flits per packet; minimum 2; N_BODY = TOTAL_FLITS-2.
- `DEPTH`, default 2: packet FIFO entries (power of two, ≥1).
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: a packet is offered.
- `pkt_head` in FLIT_W: head flit.
- `pkt_body` in N_BODY*FLIT_W: body flits; body[0] is at bits [FLIT_W-1:0].
- `pkt_tail` in FLIT_W: tail flit.
- `pkt_ready` out 1: FIFO can accept a packet.
- `o_flit` out FLIT_W: flit to the NI (`i_flit`).
- `o_enable` out 1: `o_flit` is valid (drives the NI `enable`).
- `i_ready` in 1: the NI accepts the flit.
- `tx_done` out 1: one-cycle pulse when a tail flit transfers.
- `pkt_count` out 16: number of packets fully sent; wraps 0xFFFF→0.

## Operation
- **Packet accept:** a packet is accepted on an edge where `pkt_valid && pkt_ready`, and is written to the FIFO.
  - `pkt_ready = !fifo_full && !reset`. It is derived from the registered occupancy, so it is never combinationally dependent on `pkt_valid`.
- **Flit transfer:** a flit transfers on an edge where `o_enable && i_ready`.
  - While `o_enable=1 && i_ready=0`, `o_flit` and `o_enable` hold unchanged.
- **Serializer:** holds one popped packet in a shadow register. Total capacity is therefore DEPTH+1 packets.
- **State machine:** IDLE, HEAD, BODY, TAIL.
  - IDLE: if the FIFO is non-empty, pop it, load the head into `o_flit`, set `o_enable=1` and go to HEAD.
  - HEAD, on transfer: if N_BODY>0, drive body[0] and go to BODY; else drive the tail and go to TAIL.
  - BODY: a 0..N_BODY-1 index advances on each transfer. After body[N_BODY-1] transfers, drive the tail and go to TAIL.
  - TAIL, on transfer: pulse `tx_done`; increment `pkt_count` (modulo 2^16).
    - FIFO non-empty at that edge: pop, drive the next head and go to HEAD (no bubble).
    - FIFO empty: `o_enable=0` and go to IDLE.
- **Simultaneous push/pop:** allowed in the same cycle; occupancy is unchanged. A push into an empty FIFO is not visible to the serializer until the next edge.
- **Flit contents:** flits are passed through unmodified. There is no CRC and no header decode.
- **`o_flit` when idle:** holds its last value while `o_enable=0` and must not be relied on.

## Timing
- **Reset values (after the reset edge):**
  - `o_enable=0`, `o_flit=0`, `tx_done=0`, `pkt_count=0`
  - FIFO empty, state IDLE
  - `pkt_ready=0` while `reset=1`, and 1 on the first cycle after.
- **Reset mid-packet:** aborts the packet and flushes the FIFO. `o_enable=0` from the edge where reset is sampled. No `tx_done` is issued for the aborted packet.
- **Latency:** a packet accepted at edge N into an empty FIFO with the serializer in IDLE has its head valid after edge N+1.
- **Link rate:** with `i_ready` held at 1, one flit transfers per cycle. A packet occupies exactly TOTAL_FLITS cycles, and back-to-back packets have zero idle cycles between tail and head.
- **`tx_done`:** asserted in the cycle after the tail-transfer edge, for exactly one cycle. `pkt_count` updates on the same edge.
- **Full FIFO:** `pkt_ready` deasserts the cycle after the edge that makes the FIFO full, and reasserts the cycle after a pop.
- **Index wrap:** FIFO pointers wrap modulo DEPTH.

## Test plan
- **Reset:** assert `reset` for 2 cycles during an active packet → `o_enable=0`, `pkt_count=0`, `tx_done=0` and `pkt_ready=0` during reset; `pkt_ready=1` on the cycle after release; no residual flits.
- **Single packet:** head 0xA001, body {0x1111, 0x2222}, tail 0xB00F, `i_ready=1`, accepted at edge N → `o_flit` shows 0xA001, 0x1111, 0x2222, 0xB00F after edges N+1..N+4; `o_enable=0` after N+5; `tx_done` pulses once; `pkt_count=1`.
- **Back-pressure:** same packet with `i_ready=0` for 3 cycles while 0x1111 is on `o_flit` → 0x1111 and `o_enable=1` are held stable for 3 cycles; the sequence then resumes with no flit lost or duplicated.
- **Back-to-back:** packets P0 (0xA001…0xB00F) and P1 (0xA002, 0x3333, 0x4444, 0xB010) accepted on consecutive edges → 8 flits on 8 consecutive cycles; P1 head directly follows P0 tail; two `tx_done` pulses; `pkt_count=2`.
- **Full/empty:** with `i_ready=0`, offer 4 packets continuously → exactly 3 are accepted (DEPTH+1) and `pkt_ready=0`. Raise `i_ready` → 12 flits are sent in order; `pkt_ready` returns to 1 after the first pop; the 4th packet is accepted and sent; `pkt_count=4`.
- **Counter wrap:** preload 0xFFFF sends (or force) and send one packet → `pkt_count=0x0000`; `tx_done` pulses.
